// File: rtl/imem_loadable.sv
// Loadable instruction memory: a word stream fills the array in state LOAD,
// then single-cycle-latency PC fetches are served in state RUN.
module imem_loadable #(
    parameter int              WIDTH = 32,
    parameter int              DEPTH = 256,
    parameter int              PC_W  = 32,
    parameter logic [WIDTH-1:0] NOP  = WIDTH'(32'h00000000),
    localparam int             AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    input  logic              reload,
    output logic              loading,
    output logic [AW:0]       load_count,
    output logic              load_ovf,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [WIDTH-1:0]  fetch_instr,
    output logic              fetch_err
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
    localparam logic [PC_W-3:0] DEPTH_PC = (PC_W - 2)'(DEPTH);

    state_t            r_state;
    logic [AW-1:0]     r_ptr;
    logic [AW:0]       r_load_count;
    logic              r_load_ovf;
    logic              r_fetch_valid;
    logic              r_fetch_err;
    logic [WIDTH-1:0]  r_fetch_instr;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_load_we;
    logic              w_last_slot;
    logic              w_fetch_err;
    logic [AW-1:0]     w_idx;
    logic [WIDTH-1:0]  w_rdata;

    // Reset gates the write so an asserted reset never disturbs stored words.
    assign w_load_we   = (r_state == S_LOAD) && load_valid && !reset;
    assign w_last_slot = (r_ptr == LAST_PTR);
    assign w_fetch_err = (fetch_pc[1:0] != 2'b00) || (fetch_pc[PC_W-1:2] >= DEPTH_PC);
    assign w_idx       = fetch_pc[AW+1:2];
    assign w_rdata     = r_mem[w_idx];

    // Instruction storage: written only by the load stream, never reset.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_mem[r_ptr] <= load_data;
        end
    end

    // Load/run control, overflow flag and the registered fetch response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_LOAD;
            r_ptr         <= '0;
            r_load_count  <= '0;
            r_load_ovf    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_fetch_instr <= NOP;
        end else begin
            r_fetch_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (load_valid) begin
                        r_ptr        <= r_ptr + AW'(1);
                        r_load_count <= r_load_count + (AW + 1)'(1);
                        if (load_last || w_last_slot) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (load_valid) begin
                        r_load_ovf <= 1'b1;
                    end
                    // A fetch accepted alongside reload still reads the old contents.
                    if (fetch_req) begin
                        r_fetch_valid <= 1'b1;
                        r_fetch_err   <= w_fetch_err;
                        r_fetch_instr <= w_fetch_err ? NOP : w_rdata;
                    end
                    if (reload) begin
                        r_state      <= S_LOAD;
                        r_ptr        <= '0;
                        r_load_count <= '0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign loading     = (r_state == S_LOAD);
    assign fetch_ready = (r_state == S_RUN);
    assign load_count  = r_load_count;
    assign load_ovf    = r_load_ovf;
    assign fetch_valid = r_fetch_valid;
    assign fetch_err   = r_fetch_err;
    assign fetch_instr = r_fetch_instr;

endmodule

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of instruction words (any value >= 2, not required to be a power of two).
REQ-003 SHALL have parameter PC_W, default 32, byte-address (PC) width.
REQ-004 SHALL have parameter NOP, default 32'h00000000, the word returned on an errored fetch.
REQ-005 SHALL derive AW = $clog2(DEPTH) internally; AW is not a port.
REQ-006 SHALL use one clock and an asynchronous, active-high reset:
  clk  in  1  clock, all state changes on the rising edge
  reset  in  1  asynchronous active-high reset
  load_valid  in  1  load word present this cycle
  load_data  in  WIDTH  word to write at the current load pointer
  load_last  in  1  final word of the program; qualified by load_valid
  reload  in  1  single-cycle pulse: restart program load from word 0
  loading  out  1  high while in state LOAD
  load_count  out  AW+1  words written since the last load start
  load_ovf  out  1  sticky flag: load_valid received outside LOAD
  fetch_req  in  1  fetch request
  fetch_pc  in  PC_W  byte address of the instruction
  fetch_ready  out  1  high when a fetch can be accepted
  fetch_valid  out  1  single-cycle pulse: fetch_instr/fetch_err valid
  fetch_instr  out  WIDTH  fetched instruction word
  fetch_err  out  1  accepted fetch was misaligned or out of range

Function
REQ-007 SHALL implement a two-state FSM: LOAD and RUN; loading = (state==LOAD); fetch_ready = (state==RUN).
REQ-008 SHALL write load_data to memory[ptr] and increment ptr and load_count on each cycle with state==LOAD and load_valid.
REQ-009 SHALL transition LOAD->RUN on the edge that writes a word with load_last=1, or that writes word DEPTH-1, whichever comes first.
REQ-010 SHALL, in RUN with reload=1, go to LOAD next cycle with ptr=0 and load_count=0; memory contents SHALL be kept until overwritten.
REQ-011 SHALL ignore reload while in LOAD.
REQ-012 SHALL, on load_valid while in RUN, write nothing and set load_ovf; load_ovf clears only on reset.
REQ-013 SHALL accept a fetch when fetch_req && fetch_ready, and assert fetch_valid exactly one cycle later (latency 1, registered outputs).
REQ-014 SHALL raise fetch_err and return fetch_instr=NOP when fetch_pc[1:0] != 0 or fetch_pc[PC_W-1:2] >= DEPTH; otherwise it SHALL return fetch_err=0 and fetch_instr = memory[fetch_pc[AW+1:2]].
REQ-015 SHALL accept back-to-back fetches, one per cycle, with no bubble.
REQ-016 SHALL drop a fetch_req made while fetch_ready=0, producing no fetch_valid.
REQ-017 SHALL hold fetch_instr and fetch_err at their last values when fetch_valid=0.
REQ-018 SHALL, when reload and fetch_req are both accepted in the same RUN cycle, complete the fetch with old memory contents; fetch_ready SHALL drop the next cycle.
REQ-019 SHALL not read memory contents as X after a load for words below load_count; contents of unwritten words are undefined.

Reset
REQ-020 SHALL, on reset, set state=LOAD, ptr=0, load_count=0, load_ovf=0, fetch_valid=0, fetch_err=0 and fetch_instr=NOP, asynchronously.
REQ-021 SHALL leave memory contents unchanged on reset; a reset in the middle of a load restarts the load at word 0.

Verification
REQ-022 Reset; load 4 words 0x00004020, 0x00007020, 0x0C00000F, 0x8D090040, last on the 4th -> loading falls, load_count=4; fetch pc 0x8 -> next cycle fetch_valid=1, fetch_instr=0x0C00000F, fetch_err=0.
REQ-023 In RUN, fetch pc 0x2 then pc 4*DEPTH on consecutive cycles -> two consecutive fetch_valid pulses, both fetch_err=1, fetch_instr=NOP.
REQ-024 DEPTH=4; stream 6 load words without load_last -> RUN after the 4th; the 5th and 6th set load_ovf=1 and memory[0..3] hold words 1..4.
REQ-025 fetch_req held during LOAD -> no fetch_valid; the first request in RUN returns data one cycle later.
REQ-026 Reset asserted after 2 of 4 load words; reload 2 new words with load_last -> memory[0..1] hold the new words, load_count=2.
REQ-027 In RUN, assert reload together with fetch pc 0x0 -> fetch returns the old word 0 and fetch_ready=0 the next cycle; a new load of word 0 then fetch pc 0x0 -> returns the new value.
